// File: rtl/urng_pkg.sv
// Shared definitions for the taus88 uniform random number generator bank:
// control states, taus88 shift/mask constants and the seed sanitizer.
package urng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } urng_state_e;

  // Golden-ratio salt that decorrelates the default seeds of each channel
  localparam logic [31:0] GOLDEN = 32'h9E3779B9;

  // Component 0 recurrence: mask, left shift, feedback shift, right shift
  localparam logic [31:0] S0_MASK = 32'hFFFFFFFE;
  localparam int          S0_SHL  = 12;
  localparam int          S0_FB   = 13;
  localparam int          S0_SHR  = 19;

  // Component 1 recurrence
  localparam logic [31:0] S1_MASK = 32'hFFFFFFF8;
  localparam int          S1_SHL  = 4;
  localparam int          S1_FB   = 2;
  localparam int          S1_SHR  = 25;

  // Component 2 recurrence
  localparam logic [31:0] S2_MASK = 32'hFFFFFFF0;
  localparam int          S2_SHL  = 17;
  localparam int          S2_FB   = 3;
  localparam int          S2_SHR  = 11;

  // Smallest legal value of each component and the bit forced to reach it
  localparam logic [31:0] S0_MIN = 32'd1;
  localparam logic [31:0] S1_MIN = 32'd7;
  localparam logic [31:0] S2_MIN = 32'd15;
  localparam logic [31:0] S0_FIX = 32'd2;
  localparam logic [31:0] S1_FIX = 32'd8;
  localparam logic [31:0] S2_FIX = 32'd16;

  // A component at or below its minimum would lock the recurrence at zero,
  // so force one bit above the masked-off region.
  function automatic logic [31:0] sanitize(input logic [1:0] sel, input logic [31:0] v);
    logic [31:0] r;
    r = v;
    case (sel)
      2'd0:    if (v <= S0_MIN) r = v | S0_FIX;
      2'd1:    if (v <= S1_MIN) r = v | S1_FIX;
      2'd2:    if (v <= S2_MIN) r = v | S2_FIX;
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/taus88_core.sv
// One taus88 channel: three component registers, a seed write port and the
// combined word of the next state, so the caller can capture the output on
// the same edge that advances the generator.
module taus88_core
  import urng_pkg::*;
#(
  parameter logic [31:0] P0     = 32'hFFFFFFFF,
  parameter logic [31:0] P1     = 32'hCCCCCCCD,
  parameter logic [31:0] P2     = 32'h00FF00FF,
  parameter int          CH_IDX = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_step,
  input  logic        i_seed_we,
  input  logic [1:0]  i_seed_sel,
  input  logic [31:0] i_seed_data,
  output logic [31:0] o_next_word
);

  localparam logic [31:0] SALT = 32'(CH_IDX) * GOLDEN;
  localparam logic [31:0] RST0 = sanitize(2'd0, P0 ^ SALT);
  localparam logic [31:0] RST1 = sanitize(2'd1, P1 ^ SALT);
  localparam logic [31:0] RST2 = sanitize(2'd2, P2 ^ SALT);

  logic [31:0] r_s0, r_s1, r_s2;
  logic [31:0] w_n0, w_n1, w_n2;

  assign w_n0 = ((r_s0 & S0_MASK) << S0_SHL) ^ (((r_s0 << S0_FB) ^ r_s0) >> S0_SHR);
  assign w_n1 = ((r_s1 & S1_MASK) << S1_SHL) ^ (((r_s1 << S1_FB) ^ r_s1) >> S1_SHR);
  assign w_n2 = ((r_s2 & S2_MASK) << S2_SHL) ^ (((r_s2 << S2_FB) ^ r_s2) >> S2_SHR);

  assign o_next_word = w_n0 ^ w_n1 ^ w_n2;

  // Component registers: seed writes take priority, otherwise advance on step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s0 <= RST0;
      r_s1 <= RST1;
      r_s2 <= RST2;
    end else if (i_seed_we) begin
      case (i_seed_sel)
        2'd0:    r_s0 <= sanitize(2'd0, i_seed_data);
        2'd1:    r_s1 <= sanitize(2'd1, i_seed_data);
        2'd2:    r_s2 <= sanitize(2'd2, i_seed_data);
        default: ;
      endcase
    end else if (i_step) begin
      r_s0 <= w_n0;
      r_s1 <= w_n1;
      r_s2 <= w_n2;
    end
  end

endmodule

// File: rtl/taus_urng_bank.sv
// Multi-channel taus88 bank: control FSM (idle / warm-up / run), warm-up
// discard counter, registered output word and valid/ready handshake.
module taus_urng_bank
  import urng_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          OUT_W      = 32,
  parameter int          WARMUP     = 4,
  parameter int          AUTO_START = 1,
  parameter logic [31:0] P0         = 32'hFFFFFFFF,
  parameter logic [31:0] P1         = 32'hCCCCCCCD,
  parameter logic [31:0] P2         = 32'h00FF00FF,
  localparam int         CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  input  logic [CHW-1:0]          seed_chan,
  input  logic [1:0]              seed_sel,
  input  logic [31:0]             seed_data,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam logic [7:0] WARMUP_CNT = 8'(WARMUP);
  localparam urng_state_e RST_STATE = (AUTO_START == 0) ? ST_IDLE :
                                      ((WARMUP == 0) ? ST_RUN : ST_WARMUP);

  urng_state_e r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [NUM_CH*OUT_W-1:0] r_out_data, w_out_nxt;
  logic        r_out_valid, w_valid_nxt;
  logic        w_step, w_load;
  logic [31:0] w_words [NUM_CH];

  assign seed_ready = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_WARMUP) || (r_state == ST_RUN);
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_seed_we;
    assign w_seed_we = seed_valid && seed_ready && (seed_chan == CHW'(c));

    taus88_core #(
      .P0     (P0),
      .P1     (P1),
      .P2     (P2),
      .CH_IDX (c)
    ) u_core (
      .clk         (clk),
      .resetn      (resetn),
      .i_step      (w_step),
      .i_seed_we   (w_seed_we),
      .i_seed_sel  (seed_sel),
      .i_seed_data (seed_data),
      .o_next_word (w_words[c])
    );

    assign w_out_nxt[c*OUT_W +: OUT_W] = w_words[c][31 -: OUT_W];
  end

  // Next state: warm-up steps WARMUP times then spends one cycle moving to
  // RUN; RUN steps whenever the output slot is free; stop overrides all.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step      = 1'b0;
    w_load      = 1'b0;
    w_valid_nxt = r_out_valid;
    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        if (start) w_state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
      end
      ST_WARMUP: begin
        if (r_cnt == WARMUP_CNT) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_step    = 1'b1;
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_RUN: begin
        if (!r_out_valid || out_ready) begin
          w_step      = 1'b1;
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 8'd0;
      w_step      = 1'b0;
      w_load      = 1'b0;
      w_valid_nxt = 1'b0;
    end
  end

  // State and warm-up counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= RST_STATE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output word register and its valid flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_valid_nxt;
      if (w_load) r_out_data <= w_out_nxt;
    end
  end

endmodule

// File: tb/tb_taus_urng_bank.sv
// Bench for taus_urng_bank: a single-channel bank (no warm-up, manual start)
// and a two-channel bank (warm-up 4, auto start, 16-bit outputs), both
// checked word by word against a per-channel taus88 reference model.
module tb_taus_urng_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bank A: NUM_CH=1, OUT_W=32, WARMUP=0, AUTO_START=0
  logic        aResetn = 1'b0, aStart = 1'b0, aStop = 1'b0, aSeedValid = 1'b0;
  logic        aSeedReady, aOutValid, aBusy;
  logic        aOutReady = 1'b0;
  logic [0:0]  aSeedChan = '0;
  logic [1:0]  aSeedSel = '0;
  logic [31:0] aSeedData = '0;
  logic [31:0] aOutData;

  // Bank B: NUM_CH=2, OUT_W=16, WARMUP=4, AUTO_START=1
  logic        bResetn = 1'b0, bStart = 1'b0, bStop = 1'b0, bSeedValid = 1'b0;
  logic        bSeedReady, bOutValid, bBusy;
  logic        bOutReady = 1'b0;
  logic [0:0]  bSeedChan = '0;
  logic [1:0]  bSeedSel = '0;
  logic [31:0] bSeedData = '0;
  logic [31:0] bOutData;

  taus_urng_bank #(.NUM_CH(1), .OUT_W(32), .WARMUP(0), .AUTO_START(0)) dutA (
    .clk(clk), .resetn(aResetn), .start(aStart), .stop(aStop),
    .seed_valid(aSeedValid), .seed_ready(aSeedReady), .seed_chan(aSeedChan),
    .seed_sel(aSeedSel), .seed_data(aSeedData), .out_data(aOutData),
    .out_valid(aOutValid), .out_ready(aOutReady), .busy(aBusy)
  );

  taus_urng_bank #(.NUM_CH(2), .OUT_W(16), .WARMUP(4), .AUTO_START(1)) dutB (
    .clk(clk), .resetn(bResetn), .start(bStart), .stop(bStop),
    .seed_valid(bSeedValid), .seed_ready(bSeedReady), .seed_chan(bSeedChan),
    .seed_sel(bSeedSel), .seed_data(bSeedData), .out_data(bOutData),
    .out_valid(bOutValid), .out_ready(bOutReady), .busy(bBusy)
  );

  // Reference model: generator components per channel
  logic [31:0] mA [3];
  logic [31:0] mB [2][3];
  logic [31:0] heldA;
  logic [15:0] heldB [2];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] sanitizeRef(input int k, input logic [31:0] v);
    case (k)
      0:       return (v <= 32'd1)  ? (v | 32'd2)  : v;
      1:       return (v <= 32'd7)  ? (v | 32'd8)  : v;
      default: return (v <= 32'd15) ? (v | 32'd16) : v;
    endcase
  endfunction

  function automatic logic [31:0] tausRef(input int k, input logic [31:0] s);
    case (k)
      0:       return ((s & ~32'd1)  << 12) ^ (((s << 13) ^ s) >> 19);
      1:       return ((s & ~32'd7)  << 4)  ^ (((s << 2)  ^ s) >> 25);
      default: return ((s & ~32'd15) << 17) ^ (((s << 3)  ^ s) >> 11);
    endcase
  endfunction

  function automatic logic [31:0] defaultSeed(input int k, input int c);
    logic [31:0] base;
    base = (k == 0) ? 32'hFFFFFFFF : ((k == 1) ? 32'hCCCCCCCD : 32'h00FF00FF);
    return sanitizeRef(k, base ^ (32'(c) * 32'h9E3779B9));
  endfunction

  task automatic advanceA(output logic [31:0] w);
    for (int k = 0; k < 3; k++) mA[k] = tausRef(k, mA[k]);
    w = mA[0] ^ mA[1] ^ mA[2];
  endtask

  task automatic advanceB(input int c, output logic [31:0] w);
    for (int k = 0; k < 3; k++) mB[c][k] = tausRef(k, mB[c][k]);
    w = mB[c][0] ^ mB[c][1] ^ mB[c][2];
  endtask

  task automatic resetModelB();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 3; k++) mB[c][k] = defaultSeed(k, c);
  endtask

  task automatic warmupB();
    logic [31:0] w;
    for (int c = 0; c < 2; c++)
      repeat (4) advanceB(c, w);
  endtask

  task automatic writeSeedA(input logic [0:0] ch, input logic [1:0] sel, input logic [31:0] data);
    @(negedge clk);
    aSeedValid = 1'b1; aSeedChan = ch; aSeedSel = sel; aSeedData = data;
    @(negedge clk);
    aSeedValid = 1'b0;
    if (sel != 2'd3 && ch == 1'b0) mA[sel] = sanitizeRef(int'(sel), data);
  endtask

  task automatic writeSeedB(input logic [0:0] ch, input logic [1:0] sel, input logic [31:0] data);
    @(negedge clk);
    bSeedValid = 1'b1; bSeedChan = ch; bSeedSel = sel; bSeedData = data;
    @(negedge clk);
    bSeedValid = 1'b0;
    if (sel != 2'd3) mB[ch][sel] = sanitizeRef(int'(sel), data);
  endtask

  task automatic applyStimulusStartA();
    @(negedge clk); aStart = 1'b1;
    @(negedge clk); aStart = 1'b0;
  endtask

  task automatic applyStimulusStartB();
    @(negedge clk); bStart = 1'b1;
    @(negedge clk); bStart = 1'b0;
    warmupB();
  endtask

  // Each cycle: a new word must match the model, a held word must not move
  task automatic streamA(input int cycles, input bit firstNew);
    logic [31:0] w;
    bit expectNew;
    expectNew = firstNew;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (aOutValid) begin
        if (expectNew) begin
          advanceA(w);
          heldA = w;
          checkOutput("aWord", aOutData, w);
        end else begin
          checkOutput("aHold", aOutData, heldA);
        end
      end
      aOutReady = ($urandom_range(0, 2) != 0);
      expectNew = !aOutValid || aOutReady;
    end
  endtask

  task automatic streamB(input int cycles, input bit firstNew);
    logic [31:0] w;
    bit expectNew;
    expectNew = firstNew;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bOutValid) begin
        for (int c = 0; c < 2; c++) begin
          if (expectNew) begin
            advanceB(c, w);
            heldB[c] = w[31:16];
            checkOutput("bWord", 32'(bOutData[c*16 +: 16]), 32'(w[31:16]));
          end else begin
            checkOutput("bHold", 32'(bOutData[c*16 +: 16]), 32'(heldB[c]));
          end
        end
      end
      bOutReady = ($urandom_range(0, 3) != 0);
      expectNew = !bOutValid || bOutReady;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] w, w1;
    // Reset values while both resets are held
    #12;
    checkOutput("aRstValid", 32'(aOutValid), 0);
    checkOutput("aRstData", aOutData, 0);
    checkOutput("aRstSeedRdy", 32'(aSeedReady), 1);
    checkOutput("aRstBusy", 32'(aBusy), 0);
    checkOutput("bRstValid", 32'(bOutValid), 0);
    checkOutput("bRstData", bOutData, 0);
    checkOutput("bRstBusy", 32'(bBusy), 1);
    checkOutput("bRstSeedRdy", 32'(bSeedReady), 0);

    // Bank B: auto start, seed request held during warm-up must be ignored
    @(negedge clk);
    bSeedValid = 1'b1; bSeedChan = 1'b0; bSeedSel = 2'd0; bSeedData = 32'h00012345;
    aResetn = 1'b1; bResetn = 1'b1;
    resetModelB();
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      checkOutput("bWarmValid", 32'(bOutValid), 32'(e == 6));
      checkOutput("bWarmBusy", 32'(bBusy), 1);
      checkOutput("bWarmSeedRdy", 32'(bSeedReady), 0);
    end
    bSeedValid = 1'b0;
    warmupB();
    @(negedge clk);
    advanceB(0, w);
    advanceB(1, w1);
    heldB[0] = w[31:16];
    heldB[1] = w1[31:16];
    checkOutput("bFirstCh0", 32'(bOutData[15:0]), 32'(w[31:16]));
    checkOutput("bFirstCh1", 32'(bOutData[31:16]), 32'(w1[31:16]));
    checkOutput("bChanDiffer", 32'(bOutData[15:0] != bOutData[31:16]), 1);
    streamB(60, 1'b0);

    // Reset pulse mid-stream: defaults restored, sequence restarts
    #2; bResetn = 1'b0;
    #1;
    checkOutput("bMidRstValid", 32'(bOutValid), 0);
    checkOutput("bMidRstData", bOutData, 0);
    checkOutput("bMidRstBusy", 32'(bBusy), 1);
    bResetn = 1'b1;
    resetModelB();
    warmupB();
    streamB(50, 1'b1);

    // Stop and start together: stop wins
    bStop = 1'b1; bStart = 1'b1;
    @(posedge clk); #1;
    checkOutput("bStopValid", 32'(bOutValid), 0);
    checkOutput("bStopSeedRdy", 32'(bSeedReady), 1);
    checkOutput("bStopBusy", 32'(bBusy), 0);
    bStop = 1'b0; bStart = 1'b0;

    // Random seeds (some tiny, some on the ignored select) then run
    for (int i = 0; i < 8; i++) begin
      w = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      writeSeedB(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), w);
    end
    applyStimulusStartB();
    streamB(60, 1'b1);
    bStop = 1'b1;
    @(posedge clk); #1;
    bStop = 1'b0;

    // Bank A: fixed seeds, known first words, one word per cycle
    writeSeedA(1'b0, 2'd0, 32'd2);
    writeSeedA(1'b0, 2'd1, 32'd8);
    writeSeedA(1'b0, 2'd2, 32'd16);
    aOutReady = 1'b1;
    applyStimulusStartA();
    checkOutput("aLatency", 32'(aOutValid), 0);
    checkOutput("aRunBusy", 32'(aBusy), 1);
    @(negedge clk);
    advanceA(w);
    checkOutput("aFirstValid", 32'(aOutValid), 1);
    checkOutput("aFirstWord", aOutData, 32'h00202080);
    @(negedge clk);
    advanceA(w);
    checkOutput("aSecondValid", 32'(aOutValid), 1);
    checkOutput("aSecondWord", aOutData, 32'h02002C80);
    streamA(40, 1'b1);

    // Stop with start in RUN, then restart from the retained state
    aStop = 1'b1; aStart = 1'b1;
    @(posedge clk); #1;
    checkOutput("aStopValid", 32'(aOutValid), 0);
    checkOutput("aStopSeedRdy", 32'(aSeedReady), 1);
    checkOutput("aStopBusy", 32'(aBusy), 0);
    aStop = 1'b0; aStart = 1'b0;
    applyStimulusStartA();
    streamA(30, 1'b1);
    aStop = 1'b1;
    @(posedge clk); #1;
    aStop = 1'b0;

    // Zero seed is sanitized; writes to select 3 or channel 1 are dropped
    writeSeedA(1'b0, 2'd0, 32'd0);
    writeSeedA(1'b0, 2'd1, 32'd8);
    writeSeedA(1'b0, 2'd2, 32'd16);
    writeSeedA(1'b0, 2'd3, 32'hDEADBEEF);
    writeSeedA(1'b1, 2'd0, 32'h12345678);
    aOutReady = 1'b0;
    applyStimulusStartA();
    checkOutput("aLatency2", 32'(aOutValid), 0);
    @(negedge clk);
    advanceA(w);
    checkOutput("aZeroSeedWord", aOutData, 32'h00202080);

    // Backpressure for 5 cycles: word held, nothing skipped
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("aBpValid", 32'(aOutValid), 1);
      checkOutput("aBpHold", aOutData, 32'h00202080);
    end
    aOutReady = 1'b1;
    @(negedge clk);
    advanceA(w);
    checkOutput("aBpNextValid", 32'(aOutValid), 1);
    checkOutput("aBpNextWord", aOutData, 32'h02002C80);
    streamA(30, 1'b1);
    aStop = 1'b1;
    @(posedge clk); #1;
    aStop = 1'b0;
    checkOutput("aEndValid", 32'(aOutValid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/taus_urng_bank.md
Name: taus_urng_bank

Overview:
- Multi-channel Tausworthe (taus88) uniform random number generator bank.
- NUM_CH independent three-component generators advance in lockstep; each channel's combined 32-bit output is truncated to OUT_W bits.
- Adds runtime seed loading, run/stop control, a warm-up discard phase and a valid/ready output handshake, none of which the fixed single-channel generator has.
- Feeds the AWGN (Box-Muller) stage; one bank replaces the separate a/b generators.

Parameters:
- NUM_CH, 2, number of generator channels (1..16).
- OUT_W, 32, output bits per channel; top OUT_W bits of the combined word (1..32).
- WARMUP, 4, generator steps discarded after start before out_valid may assert (0..255).
- AUTO_START, 1, when 1, WARMUP is entered directly after reset; when 0, the bank waits in IDLE.
- P0, 32'hFFFFFFFF, default s0 seed base.
- P1, 32'hCCCCCCCD, default s1 seed base.
- P2, 32'h00FF00FF, default s2 seed base.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  pulse; IDLE -> WARMUP.
- stop  in  1  pulse; any state -> IDLE.
- seed_valid  in  1  seed write request.
- seed_ready  out  1  high only in IDLE.
- seed_chan  in  clog2(NUM_CH) (min 1)  target channel.
- seed_sel  in  2  component select: 0=s0, 1=s1, 2=s2; 3 is ignored.
- seed_data  in  32  seed value.
- out_data  out  NUM_CH*OUT_W  channel c in bits [c*OUT_W +: OUT_W].
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts.
- busy  out  1  high in WARMUP or RUN.

Behaviour:
- Reset is asynchronous on resetn low.
  - Channel c state: sK = sanitize(PK ^ (c*32'h9E3779B9)).
  - Warm-up counter = 0; out_data = 0; out_valid = 0.
  - State = WARMUP if AUTO_START=1, else IDLE.
- sanitize: s0<=1 -> s0|2; s1<=7 -> s1|8; s2<=15 -> s2|16. Applied at reset defaults and on every seed write.
- Step, all channels, 32-bit arithmetic with bits shifted beyond 31 discarded:
  - s0' = ((s0&~1)<<12) ^ (((s0<<13)^s0)>>19)
  - s1' = ((s1&~7)<<4) ^ (((s1<<2)^s1)>>25)
  - s2' = ((s2&~15)<<17) ^ (((s2<<3)^s2)>>11)
  - out = (s0'^s1'^s2')[31 -: OUT_W]
- State IDLE:
  - No stepping; seed_ready=1; out_valid=0.
  - A seed write (seed_valid & seed_ready) updates the selected component next edge. seed_sel=3 or seed_chan>=NUM_CH: write dropped, no state change.
  - start -> WARMUP, or RUN if WARMUP=0.
- State WARMUP:
  - Step every cycle; counter increments.
  - After WARMUP steps -> RUN; counter cleared. out_valid stays 0.
- State RUN:
  - Step and register out_data when !out_valid | out_ready. out_valid then 1 after that edge.
  - When out_valid & !out_ready: out_data and state hold; no step.
  - Latency: if the edge entering RUN is edge k, the first word is valid after edge k+1. Back-to-back words every cycle while out_ready=1.
- stop, any state:
  - Next edge -> IDLE; out_valid cleared; the pending word is discarded; generator state is retained.
  - stop with start in the same cycle: stop wins.
  - start outside IDLE is ignored.
- Seed requests outside IDLE: seed_ready=0, request not accepted; the source holds it.
- busy = (state==WARMUP)|(state==RUN).
- resetn low mid-operation: immediate return to reset values, including defaults overwriting loaded seeds.

Decomposition:
- Package urng_pkg:
  - state enum IDLE/WARMUP/RUN.
  - taus88 shift, mask and minimum constants.
  - golden-ratio constant 32'h9E3779B9.
  - sanitize function.
- Sub-module taus88_core: one channel.
  - Three state registers, step enable, seed write port.
  - Combined 32-bit output.
  - Instantiated NUM_CH times under a generate loop.
- Top: FSM, warm-up counter, output register, handshake.

Test Plan:
- Config NUM_CH=1, WARMUP=0, AUTO_START=0.
  - Stimulus: write s0=2, s1=8, s2=16; start; hold out_ready=1.
  - Required: first word 32'h00202080, second 32'h02002C80, one word per cycle.
- Same config, seed zero.
  - Stimulus: write s0=0, s1=8, s2=16; start.
  - Required: s0 sanitized to 2; first word 32'h00202080.
- Backpressure.
  - Stimulus: out_ready=0 for 5 cycles after first valid, then 1.
  - Required: out_data stable at 32'h00202080; next word 32'h02002C80; no word skipped.
- Config NUM_CH=2, WARMUP=4, AUTO_START=1.
  - Stimulus: reset release.
  - Required: out_valid first high after edge 6 following reset release; busy=1; channels differ; seed_ready=0 throughout.
- stop and start in the same cycle during RUN.
  - Required: IDLE next edge; out_valid=0; seed_ready=1.
  - Restart continues the sequence from the retained state.
- Reset mid-stream.
  - Stimulus: resetn low for 1 ns mid-RUN.
  - Required: out_valid=0 and out_data=0 immediately; default seeds restored; the output sequence repeats the post-reset sequence exactly.
